maxnet_winner_detect: RTL and testbench
=======================================

# maxnet_winner_detect

Parametrised convergence detector and winner selector for the MaxNet datapath. Each iteration the MaxNet core presents N signed activations plus N class tags. The block counts accepted iterations and detects three outcomes: exactly one positive activation remains, all activations have died, or the iteration budget is exhausted. It then holds the winning tag, index and iteration count behind a valid/ready handshake for the downstream consumer.

## Interface
- `N`, 4: channel count, ≥2.
- `W`, 32: width of each activation and each tag; activations are two's-complement signed.
- `IDX_W`, `$clog2(N)`: winner index width.
- `ITER_W`, 8: iteration counter width.
- `MAX_ITER`, 100: iteration budget; 1 ≤ MAX_ITER ≤ 2^ITER_W−1.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a new classification; clears the iteration count.
- `in_valid`  in  1  activation beat present.
- `in_ready`  out  1  block accepts a beat (high only in RUN).
- `in_x`  in  N*W  activations; channel i at bits [i*W +: W].
- `in_tag`  in  N*W  class tags, same packing.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_code`  out  2  result code: 0 WIN, 1 NONE, 2 TIMEOUT.
- `out_idx`  out  IDX_W  winner channel index.
- `out_tag`  out  W  winner tag.
- `out_iters`  out  ITER_W  accepted beats, including the deciding beat.
- `busy`  out  1  state ≠ IDLE.

## Operation
- A channel is positive iff its activation, read as signed, is > 0. Zero and negative values count as dead.
- The positive count saturates at 2. The lowest-index positive channel is the candidate.
- States:
  - IDLE: `start` → RUN, with iter=0.
  - RUN: each accepted beat (`in_valid` && `in_ready`) does iter+1 and evaluates the beat:
    - count==1 → HOLD with WIN, idx = the positive channel.
    - count==0 → HOLD with NONE, idx=0, tag=0.
    - count≥2 and iter+1==MAX_ITER → HOLD with TIMEOUT, idx = lowest positive channel.
    - Otherwise stay in RUN.
  - HOLD: `out_valid`=1. `out_ready` → IDLE.
- Result registers (code, idx, tag, iters) load only on the deciding beat and stay stable throughout HOLD.
- `start` in RUN restarts: iter=0, the same-cycle beat is discarded, state stays RUN.
- `start` in HOLD is ignored; the result must be consumed first.
- `in_valid` outside RUN is ignored.
- Simultaneous `start` and `out_ready` in HOLD: go to IDLE only; `start` is not latched.

## Timing
- Reset values: state IDLE; `in_ready`, `out_valid`, `busy` = 0; `out_code`, `out_idx`, `out_tag`, `out_iters` = 0.
- A reset asserted mid-classification discards everything immediately.
- The decision is registered. A deciding beat accepted at edge t gives `out_valid`=1 and `in_ready`=0 from t+1.
- Throughput in RUN is one beat per cycle. There is no combinational path from `in_valid` to `in_ready`.
- `in_ready` depends only on state.
- `out_valid` stays high until the cycle `out_ready` is sampled high. It drops the next cycle; the earliest new `start` is accepted one cycle after that.

## Structure
- The package `maxnet_pkg` holds:
  - the state enum (IDLE, RUN, HOLD);
  - the result-code enum (WIN, NONE, TIMEOUT);
  - a 2-bit code width constant.
- One sub-module, `maxnet_pos_scan`. It is combinational and parametrised on N and W. Outputs:
  - the positive vector;
  - the saturating 2-bit count;
  - the lowest positive index;
  - the tag selected by that index.
- The top module holds the FSM, the iteration counter and the result registers.

## Test plan
All scenarios use N=4, W=32, MAX_ITER=5.
- Immediate win: `start`, then beat x={−3,0,7,−1}, tags={10,11,12,13}. Response: the next cycle `out_valid`=1, code WIN, idx 2, tag 12, iters 1.
- Multi-iteration win: three beats with positive counts 3, 2, 1 (last survivor ch1, tag 11). Response: WIN, idx 1, tag 11, iters 3. `in_ready` stays high through beats 1–2.
- All dead: a beat with x={0,−5,−5,0}. Response: NONE, idx 0, tag 0, iters 1.
- Timeout: five beats each with ch0 and ch3 positive. Response after beat 5: TIMEOUT, idx 0, iters 5.
- Backpressure and ignore rules:
  - hold `out_ready`=0 for 4 cycles while driving `start` and `in_valid`; outputs must stay stable and the state must stay HOLD;
  - raise `out_ready`; `out_valid` must drop the next cycle.
- Reset and restart:
  - assert `rst` asynchronously after two non-deciding beats; all outputs must go to 0 and the state to IDLE;
  - separately, `start` in RUN after 2 beats then one winning beat must give iters 1.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared types for the MaxNet winner detector: FSM states and result codes.
package maxnet_pkg;

  localparam int CODE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef enum logic [CODE_W-1:0] {
    CODE_WIN     = 2'd0,
    CODE_NONE    = 2'd1,
    CODE_TIMEOUT = 2'd2
  } code_t;

endpackage

// File: rtl/maxnet_pos_scan.sv
// Combinational scan of one activation beat: which channels are alive, how many
// (saturating at 2), and the lowest-index survivor together with its tag.
module maxnet_pos_scan
  import maxnet_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N*W-1:0] in_x,
  input  logic [N*W-1:0] in_tag,
  output logic [N-1:0]   pos,
  output logic [1:0]     pos_cnt,
  output logic [IDX_W-1:0] low_idx,
  output logic [W-1:0]   low_tag
);

  // A channel is alive only when strictly positive: sign clear and not all zero.
  always_comb begin
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos[i] = ~in_x[i*W + W - 1] & (|in_x[i*W +: W]);
    end
  end

  always_comb begin
    pos_cnt = 2'd0;
    for (int i = 0; i < N; i++) begin
      if (pos[i] && pos_cnt != 2'd2) begin
        pos_cnt = pos_cnt + 2'd1;
      end
    end
  end

  // Walk from the top down so the last hit left standing is the lowest index.
  always_comb begin
    low_idx = '0;
    low_tag = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pos[i]) begin
        low_idx = IDX_W'(i);
        low_tag = in_tag[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/maxnet_winner_detect.sv
// MaxNet convergence detector: counts accepted iterations, decides WIN / NONE /
// TIMEOUT and holds the result behind a valid/ready handshake.
module maxnet_winner_detect
  import maxnet_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int IDX_W    = $clog2(N),
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*W-1:0]       in_x,
  input  logic [N*W-1:0]       in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CODE_W-1:0]    out_code,
  output logic [IDX_W-1:0]     out_idx,
  output logic [W-1:0]         out_tag,
  output logic [ITER_W-1:0]    out_iters,
  output logic                 busy
);

  state_t             state;
  logic [ITER_W-1:0]  iter;
  logic [ITER_W-1:0]  iter_next;
  logic [N-1:0]       pos;
  logic [1:0]         pos_cnt;
  logic [IDX_W-1:0]   low_idx;
  logic [W-1:0]       low_tag;

  maxnet_pos_scan #(.N(N), .W(W), .IDX_W(IDX_W)) u_scan (
    .in_x    (in_x),
    .in_tag  (in_tag),
    .pos     (pos),
    .pos_cnt (pos_cnt),
    .low_idx (low_idx),
    .low_tag (low_tag)
  );

  assign iter_next = iter + ITER_W'(1);
  assign in_ready  = (state == ST_RUN);
  assign out_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

  // Result registers only move on the deciding beat, so HOLD presents a frozen result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      iter      <= '0;
      out_code  <= '0;
      out_idx   <= '0;
      out_tag   <= '0;
      out_iters <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            iter  <= '0;
          end
        end
        ST_RUN: begin
          if (start) begin
            iter <= '0;
          end else if (in_valid) begin
            iter <= iter_next;
            if (pos_cnt == 2'd1) begin
              state     <= ST_HOLD;
              out_code  <= CODE_WIN;
              out_idx   <= low_idx;
              out_tag   <= low_tag;
              out_iters <= iter_next;
            end else if (!(|pos)) begin
              state     <= ST_HOLD;
              out_code  <= CODE_NONE;
              out_idx   <= '0;
              out_tag   <= '0;
              out_iters <= iter_next;
            end else if (iter_next == ITER_W'(MAX_ITER)) begin
              state     <= ST_HOLD;
              out_code  <= CODE_TIMEOUT;
              out_idx   <= low_idx;
              out_tag   <= low_tag;
              out_iters <= iter_next;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_winner_detect.sv
// Scoreboard bench for maxnet_winner_detect: directed scenarios plus randomized
// classifications, checked against a transaction-level reference model.
module tb_maxnet_winner_detect;

  localparam int N        = 4;
  localparam int W        = 32;
  localparam int IDX_W    = 2;
  localparam int ITER_W   = 8;
  localparam int MAX_ITER = 5;

  localparam logic [1:0] E_WIN     = 2'd0;
  localparam logic [1:0] E_NONE    = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*W-1:0]    in_x = '0;
  logic [N*W-1:0]    in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [1:0]        out_code;
  logic [IDX_W-1:0]  out_idx;
  logic [W-1:0]      out_tag;
  logic [ITER_W-1:0] out_iters;
  logic              busy;

  typedef struct {
    logic [1:0]   code;
    int           idx;
    logic [W-1:0] tag;
    int           iters;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: the block is either running, holding a result, or idle.
  bit m_run  = 1'b0;
  bit m_hold = 1'b0;
  int m_iter = 0;

  maxnet_winner_detect #(
    .N(N), .W(W), .IDX_W(IDX_W), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_idx   (out_idx),
    .out_tag   (out_tag),
    .out_iters (out_iters),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic logic [W-1:0] rand_val(input bit positive);
    logic [W-1:0] v;
    if (positive) begin
      case ($urandom_range(0, 3))
        0:       v = 32'd1;
        1:       v = 32'h7fff_ffff;
        default: v = $urandom & 32'h7fff_ffff;
      endcase
      if (v == '0) v = 32'd1;
    end else begin
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = 32'h8000_0000;
        default: v = $urandom | 32'h8000_0000;
      endcase
    end
    return v;
  endfunction

  function automatic logic [N*W-1:0] gen_x(input logic [N-1:0] mask);
    logic [N*W-1:0] x;
    for (int i = 0; i < N; i++) x[i*W +: W] = rand_val(mask[i]);
    return x;
  endfunction

  // Decide a beat from the rules: count strictly positive signed activations.
  task automatic modelBeat(input logic [N*W-1:0] x, input logic [N*W-1:0] tg);
    int   cnt = 0;
    int   first = -1;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      logic signed [W-1:0] a;
      a = x[i*W +: W];
      if (a > 0) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    if (cnt == 1) begin
      e.code = E_WIN; e.idx = first; e.tag = tg[first*W +: W];
    end else if (cnt == 0) begin
      e.code = E_NONE; e.idx = 0; e.tag = '0;
    end else if (m_iter == MAX_ITER) begin
      e.code = E_TIMEOUT; e.idx = first; e.tag = tg[first*W +: W];
    end else begin
      return;
    end
    e.iters = m_iter;
    exp_q.push_back(e);
    m_run  = 1'b0;
    m_hold = 1'b1;
  endtask

  task automatic applyStimulus(input logic st, input logic v, input logic rdy,
                               input logic [N*W-1:0] x, input logic [N*W-1:0] tg);
    start = st; in_valid = v; out_ready = rdy; in_x = x; in_tag = tg;
    if (m_hold) begin
      if (rdy) m_hold = 1'b0;
    end else if (m_run) begin
      if (st) m_iter = 0;
      else if (v) begin
        m_iter++;
        modelBeat(x, tg);
      end
    end else if (st) begin
      m_run  = 1'b1;
      m_iter = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    logic [2:0] got, want;
    got  = {in_ready, out_valid, busy};
    want = {m_run, m_hold, m_run | m_hold};
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("[TB] FAIL %s: in_ready/out_valid/busy got %b expected %b", name, got, want);
    end
  endtask

  task automatic consume(input int delay);
    for (int i = 0; i < delay; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("hold_wait");
    end
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
    checkOutput("consume");
  endtask

  // Monitor: pops the scoreboard on each new result and checks it stays frozen.
  logic              prev_valid = 1'b0;
  logic [1:0]        held_code;
  logic [IDX_W-1:0]  held_idx;
  logic [W-1:0]      held_tag;
  logic [ITER_W-1:0] held_iters;

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && !prev_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("[TB] FAIL result: unexpected result code=%0d idx=%0d tag=%0d iters=%0d, expected none",
                   out_code, out_idx, out_tag, out_iters);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_code !== e.code || int'(out_idx) != e.idx || out_tag !== e.tag ||
              int'(out_iters) != e.iters) begin
            n_miss++;
            $display("[TB] FAIL result: got code=%0d idx=%0d tag=%0d iters=%0d, expected code=%0d idx=%0d tag=%0d iters=%0d",
                     out_code, out_idx, out_tag, out_iters, e.code, e.idx, e.tag, e.iters);
          end
        end
        held_code = out_code; held_idx = out_idx; held_tag = out_tag; held_iters = out_iters;
      end else if (out_valid && prev_valid) begin
        n_vec++;
        if (out_code !== held_code || out_idx !== held_idx || out_tag !== held_tag ||
            out_iters !== held_iters) begin
          n_miss++;
          $display("[TB] FAIL hold_stable: got code=%0d idx=%0d tag=%0d iters=%0d, expected code=%0d idx=%0d tag=%0d iters=%0d",
                   out_code, out_idx, out_tag, out_iters, held_code, held_idx, held_tag, held_iters);
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N*W-1:0] tags, two_pos;
    tags    = pack4(10, 11, 12, 13);
    two_pos = pack4(4, -1, 0, 9);

    #12;
    n_vec++;
    if ({in_ready, out_valid, busy, out_code, out_idx, out_tag, out_iters} !== '0) begin
      n_miss++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b busy=%b code=%0d idx=%0d tag=%0d iters=%0d, expected all 0",
               in_ready, out_valid, busy, out_code, out_idx, out_tag, out_iters);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_reset");

    // Immediate win
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput("start");
    applyStimulus(1'b0, 1'b1, 1'b0, pack4(-3, 0, 7, -1), tags);
    checkOutput("immediate_win");
    consume(1);

    // Multi-iteration win: 3, 2, then 1 survivor
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, pack4(5, 6, 7, -2), tags);
    checkOutput("multi_beat1");
    applyStimulus(1'b0, 1'b1, 1'b0, pack4(0, 3, -4, 2), tags);
    checkOutput("multi_beat2");
    applyStimulus(1'b0, 1'b1, 1'b0, pack4(-1, 1, 0, 0), tags);
    checkOutput("multi_win");
    consume(2);

    // All dead
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, pack4(0, -5, -5, 0), tags);
    checkOutput("all_dead");
    consume(0);

    // Timeout after MAX_ITER beats with two survivors
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < MAX_ITER; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, two_pos, tags);
      checkOutput("timeout_beat");
    end
    consume(1);

    // Backpressure: start and beats ignored while holding, then simultaneous start+ready
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, pack4(0, 0, 0, 8), tags);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, pack4(0, -5, -5, 0), tags);
      checkOutput("backpressure");
    end
    applyStimulus(1'b1, 1'b0, 1'b1, '0, '0);
    checkOutput("ready_with_start");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("idle_after_hold");

    // Asynchronous reset mid-classification
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, two_pos, tags);
    applyStimulus(1'b0, 1'b1, 1'b0, two_pos, tags);
    checkOutput("pre_reset_run");
    #3 rst = 1'b1;
    #1;
    m_run = 1'b0; m_hold = 1'b0; m_iter = 0;
    n_vec++;
    if ({in_ready, out_valid, busy, out_code, out_idx, out_tag, out_iters} !== '0) begin
      n_miss++;
      $display("[TB] FAIL async_reset: got rdy=%b vld=%b busy=%b code=%0d idx=%0d tag=%0d iters=%0d, expected all 0",
               in_ready, out_valid, busy, out_code, out_idx, out_tag, out_iters);
    end
    #1 rst = 1'b0;

    // Restart in RUN discards the same-cycle beat and clears the count
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, two_pos, tags);
    applyStimulus(1'b0, 1'b1, 1'b0, two_pos, tags);
    applyStimulus(1'b1, 1'b1, 1'b0, pack4(0, 0, 3, 0), tags);
    checkOutput("restart");
    applyStimulus(1'b0, 1'b1, 1'b0, pack4(-7, 2, 0, -1), tags);
    checkOutput("restart_win");
    consume(1);

    // Randomized classifications with valid gaps and variable consume delay
    for (int k = 0; k < 30; k++) begin
      logic [N*W-1:0] rtags;
      rtags = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      checkOutput("rand_start");
      for (int g = 0; g < 40 && m_run; g++) begin
        logic [N-1:0] mask;
        logic         v;
        mask = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) < 7) begin
          int a, b;
          a = $urandom_range(0, N - 1);
          b = (a + $urandom_range(1, N - 1)) % N;
          mask = mask | (4'b1 << a) | (4'b1 << b);
        end
        v = ($urandom_range(0, 3) != 0);
        applyStimulus(1'b0, v, 1'b0, gen_x(mask), rtags);
        checkOutput("rand_beat");
      end
      consume($urandom_range(0, 3));
    end

    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
